// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Hits complete in the access cycle; misses stall the pipeline while a line is written back and/or fetched.
module dcache_ctrl #(
   parameter int unsigned SETS   = 32,
   parameter int unsigned LINE_W = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic              memread_i,
   input  logic              memwrite_i,
   input  logic [31:0]       addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o,
   output logic              stall_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [31:0]       mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i
);

   localparam int unsigned IDX_W  = $clog2(SETS);
   localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
   localparam int unsigned WORD_W = OFF_W - 2;
   localparam int unsigned TAG_W  = 32 - IDX_W - OFF_W;

   typedef enum logic [1:0] {IDLE, WB, FETCH, FILL} state_t;

   state_t            state;
   logic [LINE_W-1:0] data_q [SETS];
   logic [TAG_W-1:0]  tag_q  [SETS];
   logic [SETS-1:0]   valid_q;
   logic [SETS-1:0]   dirty_q;
   logic [TAG_W-1:0]  miss_tag;
   logic [IDX_W-1:0]  miss_idx;

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic [WORD_W-1:0] word;
   logic              access;
   logic              hit;
   logic              is_load;
   logic              unused_bits;

   assign idx         = addr_i[OFF_W +: IDX_W];
   assign tag         = addr_i[31 -: TAG_W];
   assign word        = addr_i[2 +: WORD_W];
   assign unused_bits = ^addr_i[1:0];
   assign access      = req_i & (memread_i | memwrite_i);
   assign is_load     = memread_i & ~memwrite_i;
   assign hit         = valid_q[idx] & (tag_q[idx] == tag);

   // Zero-latency load path; only a load hit in IDLE returns data
   always_comb begin
      rdata_o = '0;
      if ((state == IDLE) && access && is_load && hit)
         rdata_o = data_q[idx][{word, 5'b0} +: 32];
   end

   assign stall_o = (state != IDLE) | (access & ~hit);

   // Miss address is latched so the fill completes even if req_i drops
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state        <= IDLE;
         valid_q      <= '0;
         dirty_q      <= '0;
         miss_tag     <= '0;
         miss_idx     <= '0;
         mem_enable_o <= 1'b0;
         mem_write_o  <= 1'b0;
         mem_addr_o   <= '0;
         mem_data_o   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (access && hit) begin
                  if (memwrite_i) begin
                     data_q[idx][{word, 5'b0} +: 32] <= wdata_i;
                     dirty_q[idx]                    <= 1'b1;
                  end
               end else if (access) begin
                  miss_tag     <= tag;
                  miss_idx     <= idx;
                  mem_enable_o <= 1'b1;
                  if (valid_q[idx] && dirty_q[idx]) begin
                     state       <= WB;
                     mem_write_o <= 1'b1;
                     mem_addr_o  <= {tag_q[idx], idx, OFF_W'(0)};
                     mem_data_o  <= data_q[idx];
                  end else begin
                     state       <= FETCH;
                     mem_write_o <= 1'b0;
                     mem_addr_o  <= {tag, idx, OFF_W'(0)};
                  end
               end
            end
            WB: begin
               // Request stays up; it turns into the fetch once the write-back is acknowledged
               if (mem_ack_i) begin
                  state       <= FETCH;
                  mem_write_o <= 1'b0;
                  mem_addr_o  <= {miss_tag, miss_idx, OFF_W'(0)};
               end
            end
            FETCH: begin
               if (mem_ack_i) begin
                  state            <= FILL;
                  mem_enable_o     <= 1'b0;
                  data_q[miss_idx] <= mem_data_i;
               end
            end
            FILL: begin
               tag_q[miss_idx]   <= miss_tag;
               valid_q[miss_idx] <= 1'b1;
               dirty_q[miss_idx] <= 1'b0;
               state             <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: hit vectors from a table plus hand-written miss, eviction,
// reset-abort and ack-latency sequences against a behavioural line memory.
module tb_dcache_ctrl;

   logic         clk = 1'b0;
   logic         rst_i;
   logic         req_i, memread_i, memwrite_i;
   logic [31:0]  addr_i, wdata_i;
   logic [31:0]  rdata_o;
   logic         stall_o;
   logic         mem_enable_o, mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o, mem_data_i;
   logic         mem_ack_i;

   logic         mem_ack = 1'b0;
   logic         manual_ack = 1'b0;
   logic         mem_off = 1'b0;
   int           lat = 0;
   int           cnt = 0;
   logic         waiting = 1'b0;
   int           proto_err = 0;
   logic [255:0] mem [bit [31:0]];
   logic [32:0]  txn_q [$];
   logic [255:0] last_wb = '0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;
   assign mem_ack_i = mem_ack | manual_ack;

   dcache_ctrl dut (
      .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .memread_i(memread_i),
      .memwrite_i(memwrite_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .rdata_o(rdata_o), .stall_o(stall_o), .mem_enable_o(mem_enable_o),
      .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
   );

   function automatic logic [255:0] mkline(input logic [31:0] a);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[w*32 +: 32] = {a[15:0], 16'(w)};
      return l;
   endfunction

   function automatic logic [255:0] rd_mem(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return mkline(a);
   endfunction

   // Line memory: acks after lat idle cycles, one pulse per request
   always @(negedge clk) begin
      if (mem_ack) mem_ack = 1'b0;
      if (!rst_i) begin
         cnt = 0; waiting = 1'b0;
      end else if (mem_off) begin
         cnt = 0;
      end else if (mem_enable_o) begin
         waiting = 1'b1;
         if (cnt >= lat) begin
            if (mem_addr_o[4:0] != 5'd0) proto_err++;
            txn_q.push_back({mem_write_o, mem_addr_o});
            if (mem_write_o) begin
               mem[mem_addr_o] = mem_data_o;
               last_wb = mem_data_o;
            end else begin
               mem_data_i = rd_mem(mem_addr_o);
            end
            mem_ack = 1'b1; cnt = 0; waiting = 1'b0;
         end else begin
            cnt++;
         end
      end else begin
         if (waiting) proto_err++;
         cnt = 0;
      end
   end

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk256(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic go_idle();
      @(posedge clk); #1;
      req_i = 1'b0; memread_i = 1'b0; memwrite_i = 1'b0;
   endtask

   // Issue one access and wait (bounded) for stall to clear; drop req after drop_at stall cycles if nonzero
   task automatic do_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                            input int drop_at, output int ncyc, output logic [31:0] rv);
      @(posedge clk); #1;
      req_i = 1'b1; memread_i = rd; memwrite_i = wr; addr_i = a; wdata_i = wd;
      ncyc = 0;
      forever begin
         @(negedge clk);
         if (!stall_o) break;
         ncyc++;
         if (drop_at != 0 && ncyc == drop_at) req_i = 1'b0;
         if (ncyc > 200) begin
            checks++; errors++;
            $display("FAIL timeout: stall still high after %0d cycles at addr %h", ncyc, a);
            break;
         end
      end
      rv = rdata_o;
   endtask

   typedef struct {
      logic        req, rd, wr;
      logic [31:0] addr, wdata, exp_rdata;
      logic        exp_stall;
   } vec_t;

   vec_t vecs [12];

   initial begin
      int n;
      logic [31:0] r;
      logic [255:0] exp_line;
      int l;
      logic [31:0] a_lo, a_hi;

      exp_line = mkline(32'h40);
      exp_line[31:0] = 32'hDEADBEEF;
      mem[32'h40] = exp_line;

      vecs[0]  = '{1, 1, 0, 32'h40, 0, 32'hDEADBEEF, 0};
      vecs[1]  = '{1, 1, 0, 32'h48, 0, 32'h00400002, 0};
      vecs[2]  = '{0, 1, 0, 32'h40, 0, 32'h0, 0};
      vecs[3]  = '{1, 0, 0, 32'h40, 0, 32'h0, 0};
      vecs[4]  = '{1, 0, 1, 32'h44, 32'h12345678, 32'h0, 0};
      vecs[5]  = '{1, 1, 0, 32'h44, 0, 32'h12345678, 0};
      vecs[6]  = '{1, 1, 0, 32'h47, 0, 32'h12345678, 0};
      vecs[7]  = '{1, 1, 0, 32'h5C, 0, 32'h00400007, 0};
      vecs[8]  = '{1, 1, 1, 32'h58, 32'hAAAA5555, 32'h0, 0};
      vecs[9]  = '{1, 1, 0, 32'h58, 0, 32'hAAAA5555, 0};
      vecs[10] = '{0, 0, 1, 32'h4C, 32'hFFFFFFFF, 32'h0, 0};
      vecs[11] = '{1, 1, 0, 32'h4C, 0, 32'h00400003, 0};

      rst_i = 1'b0; req_i = 1'b0; memread_i = 1'b0; memwrite_i = 1'b0;
      addr_i = '0; wdata_i = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk32("rst stall", 32'(stall_o), 0);
      chk32("rst mem_enable", 32'(mem_enable_o), 0);
      chk32("rst mem_write", 32'(mem_write_o), 0);
      chk32("rst mem_addr", mem_addr_o, 0);
      chk256("rst mem_data", mem_data_o, '0);
      chk32("rst rdata", rdata_o, 0);
      @(posedge clk); #1; rst_i = 1'b1;

      // Cold load miss, clean fetch
      lat = 2; txn_q.delete();
      do_access(1, 0, 32'h40, 0, 0, n, r);
      chk32("t1 stall cycles", n, 5);
      chk32("t1 rdata", r, 32'hDEADBEEF);
      chk32("t1 txn count", txn_q.size(), 1);
      chk32("t1 fetch addr", txn_q[0][31:0], 32'h40);
      chk32("t1 fetch is read", 32'(txn_q[0][32]), 0);

      foreach (vecs[i]) begin
         @(posedge clk); #1;
         req_i = vecs[i].req; memread_i = vecs[i].rd; memwrite_i = vecs[i].wr;
         addr_i = vecs[i].addr; wdata_i = vecs[i].wdata;
         @(negedge clk);
         chk32($sformatf("vec%0d rdata", i), rdata_o, vecs[i].exp_rdata);
         chk32($sformatf("vec%0d stall", i), 32'(stall_o), 32'(vecs[i].exp_stall));
      end
      chk32("hits no txn", txn_q.size(), 1);
      go_idle();

      // Alias eviction of dirty line
      lat = 1; txn_q.delete();
      do_access(1, 0, 32'h444, 0, 0, n, r);
      chk32("t3 stall cycles", n, 6);
      chk32("t3 rdata", r, 32'h04400001);
      chk32("t3 txn count", txn_q.size(), 2);
      chk32("t3 wb addr", {txn_q[0][32], txn_q[0][31:0]} == {1'b1, 32'h40} ? 32'd1 : 32'd0, 1);
      chk32("t3 fetch addr", {txn_q[1][32], txn_q[1][31:0]} == {1'b0, 32'h440} ? 32'd1 : 32'd0, 1);
      exp_line[63:32]   = 32'h12345678;
      exp_line[223:192] = 32'hAAAA5555;
      chk256("t3 wb data", last_wb, exp_line);
      txn_q.delete();
      do_access(1, 0, 32'h44, 0, 0, n, r);
      chk32("t3 reload rdata", r, 32'h12345678);
      chk32("t3 clean evict txn", txn_q.size(), 1);
      go_idle();

      // Store miss to clean set, then clean and dirty evictions
      lat = 0; txn_q.delete();
      do_access(0, 1, 32'h84, 32'hCAFEF00D, 0, n, r);
      chk32("t4 stall cycles", n, 3);
      chk32("t4 txn count", txn_q.size(), 1);
      chk32("t4 fetch addr", {txn_q[0][32], txn_q[0][31:0]} == {1'b0, 32'h80} ? 32'd1 : 32'd0, 1);
      do_access(1, 0, 32'h84, 0, 0, n, r);
      chk32("t4 stored word", r, 32'hCAFEF00D);
      do_access(1, 0, 32'h80, 0, 0, n, r);
      chk32("t4 fetched word0", r, 32'h00800000);
      txn_q.delete();
      do_access(1, 0, 32'h440, 0, 0, n, r);
      chk32("t4 other set no wb", txn_q.size(), 1);
      txn_q.delete();
      do_access(1, 0, 32'h480, 0, 0, n, r);
      chk32("t4 dirty evict txn", txn_q.size(), 2);
      exp_line = mkline(32'h80);
      exp_line[63:32] = 32'hCAFEF00D;
      chk256("t4 wb data", last_wb, exp_line);
      go_idle();

      // Reset during FETCH, late ack ignored
      mem_off = 1'b1; txn_q.delete();
      @(posedge clk); #1;
      req_i = 1'b1; memread_i = 1'b1; memwrite_i = 1'b0; addr_i = 32'h40;
      @(negedge clk);
      chk32("t5 miss stall", 32'(stall_o), 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk32("t5 fetch enable", 32'(mem_enable_o), 1);
      chk32("t5 fetch addr", mem_addr_o, 32'h40);
      @(posedge clk); #1; rst_i = 1'b0; req_i = 1'b0;
      @(posedge clk); #1; rst_i = 1'b1; manual_ack = 1'b1;
      @(negedge clk);
      chk32("t5 enable after rst", 32'(mem_enable_o), 0);
      chk32("t5 addr after rst", mem_addr_o, 0);
      @(posedge clk); #1; manual_ack = 1'b0;
      @(negedge clk);
      chk32("t5 ack ignored", 32'(mem_enable_o), 0);
      chk32("t5 idle stall", 32'(stall_o), 0);
      mem_off = 1'b0; lat = 1;
      do_access(1, 0, 32'h40, 0, 0, n, r);
      chk32("t5 remiss cycles", n, 4);
      chk32("t5 rdata", r, 32'hDEADBEEF);
      chk32("t5 txn count", txn_q.size(), 1);
      go_idle();

      // Ack latency sweep with req dropped mid-miss
      for (int i = 0; i < 3; i++) begin
         l = (i == 0) ? 0 : (i == 1) ? 1 : 10;
         lat = l;
         a_lo = 32'h100 + 32'(i * 32);
         a_hi = a_lo + 32'h400;
         txn_q.delete();
         do_access(0, 1, a_lo + 32'd4, 32'h60000000 + 32'(i), 0, n, r);
         chk32($sformatf("t6 lat%0d store cycles", l), n, 32'(l + 3));
         chk32($sformatf("t6 lat%0d store txn", l), txn_q.size(), 1);
         go_idle();
         txn_q.delete();
         do_access(1, 0, a_hi + 32'd4, 0, 2, n, r);
         chk32($sformatf("t6 lat%0d drop cycles", l), n, 32'(2 * l + 4));
         chk32($sformatf("t6 lat%0d drop txn", l), txn_q.size(), 2);
         chk32($sformatf("t6 lat%0d order", l),
               (txn_q[0] == {1'b1, a_lo} && txn_q[1] == {1'b0, a_hi}) ? 32'd1 : 32'd0, 1);
         exp_line = mkline(a_lo);
         exp_line[63:32] = 32'h60000000 + 32'(i);
         chk256($sformatf("t6 lat%0d wb data", l), last_wb, exp_line);
         do_access(1, 0, a_hi + 32'd4, 0, 0, n, r);
         chk32($sformatf("t6 lat%0d installed", l), n, 0);
         chk32($sformatf("t6 lat%0d rdata", l), r, {a_hi[15:0], 16'h0001});
         go_idle();
      end

      chk32("protocol", proto_err, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
